// File: rtl/fetch_queue.sv
// Instruction fetch front end: issues one imem request at a time and buffers returned words
// with their PCs in a DEPTH-entry circular queue; redirect flushes the queue and squashes in-flight data.
module fetch_queue #(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_addr,
   input  logic            stall,
   output logic            imem_request,
   output logic            imem_we_re,
   output logic [3:0]      imem_mask,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_valid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [XLEN-1:0] instruction,
   output logic [XLEN-1:0] inst_pc,
   output logic [XLEN-1:0] inst_pc_next
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [XLEN-1:0] q_inst [DEPTH];
   logic [XLEN-1:0] q_pc   [DEPTH];
   logic [AW-1:0]   head;
   logic [AW-1:0]   tail;
   logic [CW-1:0]   count;
   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] req_pc;
   logic            outstanding;
   logic            stale;
   logic            running;
   logic            push;
   logic            pop;
   logic [CW:0]     occupancy;

   // Reserve a slot for the in-flight response so a push can never hit a full queue.
   assign occupancy    = {1'b0, count} + {{CW{1'b0}}, outstanding};
   assign imem_request = rst && running && !outstanding && !stall && !redirect
                         && (occupancy < (CW+1)'(DEPTH));
   assign imem_we_re   = 1'b0;
   assign imem_mask    = 4'b1111;
   assign imem_addr    = fetch_pc;

   assign push = imem_valid && outstanding && !stale && !redirect;
   assign pop  = inst_valid && inst_ready && !redirect;

   assign inst_valid   = (count != '0);
   assign instruction  = q_inst[head];
   assign inst_pc      = q_pc[head];
   assign inst_pc_next = q_pc[head] + XLEN'(4);

   always_ff @(posedge clk) begin
      if (push) begin
         q_inst[tail] <= imem_rdata;
         q_pc[tail]   <= req_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         fetch_pc    <= RESET_PC;
         req_pc      <= '0;
         count       <= '0;
         head        <= '0;
         tail        <= '0;
         outstanding <= 1'b0;
         stale       <= 1'b0;
         running     <= 1'b0;
      end else begin
         running <= 1'b1;
         // Any returning response retires the outstanding slot, whether kept or dropped.
         if (imem_valid) begin
            outstanding <= 1'b0;
            stale       <= 1'b0;
         end else if (redirect && outstanding) begin
            stale <= 1'b1;
         end

         if (redirect) begin
            fetch_pc <= redirect_addr;
            count    <= '0;
            head     <= '0;
            tail     <= '0;
         end else begin
            if (imem_request) begin
               outstanding <= 1'b1;
               req_pc      <= fetch_pc;
               fetch_pc    <= fetch_pc + XLEN'(4);
            end
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
         end
      end
   end
endmodule
